irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 107 ++++++++++
 tb/tb_irq_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: machine-mode trap arbiter with a memory-mapped 64-bit timer and software interrupt.
// Traps are issued as a one-cycle flush, then a settle cycle lets the CSR update land.
module irq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_irq_i,
    input  logic [31:0] except_i,
    input  logic [31:0] inst_addr_i,
    input  logic        inst_valid_i,
    input  logic        stall_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic        tmr_we_i,
    input  logic [2:0]  tmr_addr_i,
    input  logic [31:0] tmr_wdata_i,
    output logic [31:0] tmr_rdata_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [31:0] pending_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;
    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d, mtime_inc;
    logic        msip_q, msip_d, tmr_pend_q, tmr_pend_d;
    logic [31:0] code_q, code_d, addr_q, addr_d, pc_q, pc_d, code_sel, pc_sel;
    logic        ext_en, tmr_en, sw_en, take, go;
    logic        unused_ok;

    assign unused_ok = ^{mstatus_i[31:4], mstatus_i[2:0], mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0], mtvec_i[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            tmr_pend_q <= 1'b0;
            code_q     <= '0;
            addr_q     <= '0;
            pc_q       <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= ext_irq_i;
            sync2_q    <= sync1_q;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            tmr_pend_q <= tmr_pend_d;
            code_q     <= code_d;
            addr_q     <= addr_d;
            pc_q       <= pc_d;
        end
    end

    // A write to one mtime half freezes the other half for that cycle.
    always_comb begin
        mtime_inc   = mtime_q + 64'd1;
        mtime_d     = !tmr_we_i ? mtime_inc :
                      tmr_addr_i == 3'd0 ? {mtime_q[63:32], tmr_wdata_i} :
                      tmr_addr_i == 3'd1 ? {tmr_wdata_i, mtime_q[31:0]} : mtime_inc;
        mtimecmp_d  = !tmr_we_i ? mtimecmp_q :
                      tmr_addr_i == 3'd2 ? {mtimecmp_q[63:32], tmr_wdata_i} :
                      tmr_addr_i == 3'd3 ? {tmr_wdata_i, mtimecmp_q[31:0]} : mtimecmp_q;
        msip_d      = (tmr_we_i && tmr_addr_i == 3'd4) ? tmr_wdata_i[0] : msip_q;
        tmr_pend_d  = mtime_q >= mtimecmp_q;
        tmr_rdata_o = tmr_addr_i == 3'd0 ? mtime_q[31:0] :
                      tmr_addr_i == 3'd1 ? mtime_q[63:32] :
                      tmr_addr_i == 3'd2 ? mtimecmp_q[31:0] :
                      tmr_addr_i == 3'd3 ? mtimecmp_q[63:32] :
                      tmr_addr_i == 3'd4 ? {31'd0, msip_q} : 32'd0;
    end

    always_comb begin
        pending_o = {20'd0, sync2_q, 3'd0, tmr_pend_q, 3'd0, msip_q, 3'd0};
        ext_en    = mstatus_i[3] && mie_i[11] && sync2_q;
        tmr_en    = mstatus_i[3] && mie_i[7] && tmr_pend_q;
        sw_en     = mstatus_i[3] && mie_i[3] && msip_q;
        take      = (except_i != 32'd0 || ext_en || tmr_en || sw_en) && inst_valid_i && !stall_i;
        code_sel  = except_i != 32'd0 ? except_i :
                    ext_en ? 32'h8000_000B :
                    tmr_en ? 32'h8000_0007 : 32'h8000_0000;
        pc_sel    = except_i == 32'h0000_000A ? mepc_i : {mtvec_i[31:2], 2'b00};
        go        = state_q == IDLE && take;
        code_d    = go ? code_sel : code_q;
        addr_d    = go ? inst_addr_i : addr_q;
        pc_d      = go ? pc_sel : pc_q;
    end

    always_comb begin
        state_d = state_q == IDLE ? (take ? ISSUE : IDLE) :
                  state_q == ISSUE ? SETTLE : IDLE;
    end

    always_comb begin
        flush_o             = state_q == ISSUE;
        excepttype_o        = flush_o ? code_q : 32'd0;
        current_inst_addr_o = addr_q;
        new_pc_o            = pc_q;
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed vectors with hand-computed expectations for irq_ctrl.
module tb_irq_ctrl;
    logic        clk = 1'b0;
    logic        rst, ext_irq_i, inst_valid_i, stall_i, tmr_we_i, flush_o;
    logic [31:0] except_i, inst_addr_i, mstatus_i, mie_i, mtvec_i, mepc_i, tmr_wdata_i;
    logic [2:0]  tmr_addr_i;
    logic [31:0] tmr_rdata_o, excepttype_o, current_inst_addr_o, new_pc_o, pending_o;
    int          n_tests = 0, n_fail = 0;
    logic        seen;

    irq_ctrl dut (
        .clk(clk), .rst(rst), .ext_irq_i(ext_irq_i), .except_i(except_i),
        .inst_addr_i(inst_addr_i), .inst_valid_i(inst_valid_i), .stall_i(stall_i),
        .mstatus_i(mstatus_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .tmr_we_i(tmr_we_i), .tmr_addr_i(tmr_addr_i), .tmr_wdata_i(tmr_wdata_i),
        .tmr_rdata_o(tmr_rdata_o), .excepttype_o(excepttype_o),
        .current_inst_addr_o(current_inst_addr_o), .flush_o(flush_o),
        .new_pc_o(new_pc_o), .pending_o(pending_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; ext_irq_i = 1'b0; except_i = '0; inst_addr_i = '0; inst_valid_i = 1'b0;
        stall_i = 1'b0; mstatus_i = '0; mie_i = '0; mtvec_i = 32'h8000_1003; mepc_i = 32'h100;
        tmr_we_i = 1'b0; tmr_addr_i = 3'd2; tmr_wdata_i = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_flush", {31'd0, flush_o}, 32'd0);
        check("rst_excepttype", excepttype_o, 32'd0);
        check("rst_cur_addr", current_inst_addr_o, 32'd0);
        check("rst_new_pc", new_pc_o, 32'd0);
        check("rst_pending", pending_o, 32'd0);
        check("rst_mtimecmp_lo", tmr_rdata_o, 32'hFFFF_FFFF);
        tmr_addr_i = 3'd3; #1 check("rst_mtimecmp_hi", tmr_rdata_o, 32'hFFFF_FFFF);
        tmr_addr_i = 3'd0; #1 check("rst_mtime_lo", tmr_rdata_o, 32'd0);
        rst = 1'b0;
        // timer register map
        tmr_we_i = 1'b1; tmr_addr_i = 3'd0; tmr_wdata_i = 32'd5;
        @(negedge clk); tmr_we_i = 1'b0;
        #1 check("mtime_lo_wr", tmr_rdata_o, 32'd5);
        tmr_addr_i = 3'd1; #1 check("mtime_hi_hold", tmr_rdata_o, 32'd0);
        @(negedge clk); tmr_addr_i = 3'd0;
        #1 check("mtime_inc", tmr_rdata_o, 32'd6);
        tmr_we_i = 1'b1; tmr_addr_i = 3'd4; tmr_wdata_i = 32'd3;
        @(negedge clk); tmr_we_i = 1'b0;
        #1 check("msip_bit0", tmr_rdata_o, 32'd1);
        check("pending_sw", pending_o, 32'h8);
        tmr_we_i = 1'b1; tmr_addr_i = 3'd5; tmr_wdata_i = 32'hFFFF;
        @(negedge clk); tmr_we_i = 1'b0;
        #1 check("bad_addr_rd", tmr_rdata_o, 32'd0);
        tmr_we_i = 1'b1; tmr_addr_i = 3'd4; tmr_wdata_i = 32'd0;
        @(negedge clk); tmr_we_i = 1'b0;
        // 64-bit wrap
        tmr_we_i = 1'b1; tmr_addr_i = 3'd0; tmr_wdata_i = 32'hFFFF_FFFF;
        @(negedge clk); tmr_addr_i = 3'd1;
        @(negedge clk); tmr_we_i = 1'b0;
        #1 check("wrap_hi_wr", tmr_rdata_o, 32'hFFFF_FFFF);
        tmr_addr_i = 3'd0; #1 check("wrap_lo_held", tmr_rdata_o, 32'hFFFF_FFFF);
        @(negedge clk);
        #1 check("wrap_lo_zero", tmr_rdata_o, 32'd0);
        tmr_addr_i = 3'd1; #1 check("wrap_hi_zero", tmr_rdata_o, 32'd0);
        // timer interrupt
        mstatus_i = 32'h8; mie_i = 32'h80; inst_valid_i = 1'b1; inst_addr_i = 32'h2000;
        tmr_we_i = 1'b1; tmr_addr_i = 3'd2; tmr_wdata_i = 32'h10;
        @(negedge clk); tmr_addr_i = 3'd3; tmr_wdata_i = 32'd0;
        @(negedge clk); tmr_we_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            seen = pending_o[7];
        end
        check("tmr_pend_seen", {31'd0, seen}, 32'd1);
        @(negedge clk);
        check("tmr_excepttype", excepttype_o, 32'h8000_0007);
        check("tmr_flush", {31'd0, flush_o}, 32'd1);
        check("tmr_new_pc", new_pc_o, 32'h8000_1000);
        check("tmr_cur_addr", current_inst_addr_o, 32'h2000);
        mie_i = 32'd0;
        @(negedge clk);
        check("settle_flush", {31'd0, flush_o}, 32'd0);
        check("settle_excepttype", excepttype_o, 32'd0);
        check("settle_new_pc_hold", new_pc_o, 32'h8000_1000);
        check("settle_cur_hold", current_inst_addr_o, 32'h2000);
        @(negedge clk);
        // external + software, deferred by stall
        stall_i = 1'b1; ext_irq_i = 1'b1; mie_i = 32'h808; inst_addr_i = 32'h3000;
        tmr_we_i = 1'b1; tmr_addr_i = 3'd4; tmr_wdata_i = 32'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); tmr_we_i = 1'b0;
            check("stall_noflush", {31'd0, flush_o}, 32'd0);
        end
        stall_i = 1'b0;
        @(negedge clk);
        check("ext_excepttype", excepttype_o, 32'h8000_000B);
        check("ext_flush", {31'd0, flush_o}, 32'd1);
        check("ext_cur_addr", current_inst_addr_o, 32'h3000);
        ext_irq_i = 1'b0;
        @(negedge clk);
        check("ext_settle", {31'd0, flush_o}, 32'd0);
        @(negedge clk);
        check("ext_idle", {31'd0, flush_o}, 32'd0);
        @(negedge clk);
        check("sw_excepttype", excepttype_o, 32'h8000_0000);
        check("sw_flush", {31'd0, flush_o}, 32'd1);
        mie_i = 32'd0; tmr_we_i = 1'b1; tmr_addr_i = 3'd4; tmr_wdata_i = 32'd0;
        @(negedge clk); tmr_we_i = 1'b0;
        @(negedge clk);
        // exception beats pending timer
        mie_i = 32'h80; except_i = 32'h8; inst_addr_i = 32'h4444;
        @(negedge clk);
        check("ecall_excepttype", excepttype_o, 32'h8);
        check("ecall_cur_addr", current_inst_addr_o, 32'h4444);
        check("ecall_new_pc", new_pc_o, 32'h8000_1000);
        except_i = 32'd0; mie_i = 32'd0;
        repeat (2) @(negedge clk);
        // mret
        except_i = 32'hA; inst_addr_i = 32'h5000;
        @(negedge clk);
        check("mret_flush", {31'd0, flush_o}, 32'd1);
        check("mret_new_pc", new_pc_o, 32'h100);
        check("mret_excepttype", excepttype_o, 32'hA);
        except_i = 32'd0;
        @(negedge clk);
        check("mret_pc_hold", new_pc_o, 32'h100);
        check("mret_settle_exc", excepttype_o, 32'd0);
        @(negedge clk);
        // invalid slot blocks traps, then async reset mid-ISSUE
        inst_valid_i = 1'b0; except_i = 32'h2;
        @(negedge clk);
        check("invalid_noflush1", {31'd0, flush_o}, 32'd0);
        @(negedge clk);
        check("invalid_noflush2", {31'd0, flush_o}, 32'd0);
        inst_valid_i = 1'b1;
        @(negedge clk);
        check("illegal_flush", {31'd0, flush_o}, 32'd1);
        check("illegal_excepttype", excepttype_o, 32'h2);
        except_i = 32'd0; rst = 1'b1;
        #1;
        check("async_rst_flush", {31'd0, flush_o}, 32'd0);
        check("async_rst_exc", excepttype_o, 32'd0);
        check("async_rst_pc", new_pc_o, 32'd0);
        @(negedge clk); rst = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
